inst_fetch_pf: RTL

//  Parametrised successor of the IF stage: PC generator plus prefetch queue in front of a

---
 rtl/inst_fetch_pf_if.sv | 25 ++
 rtl/inst_fetch_pf.sv | 134 +++++++++++++
 2 files changed

// File: rtl/inst_fetch_pf_if.sv
// rtl/inst_fetch_pf_if.sv - redirect, instruction-memory and ID-presentation signals of the fetch stage
interface inst_fetch_pf_if;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        id_ready;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_inst;
    logic        if_adel;

    modport master (
        input  redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
        output imem_req, imem_addr, if_valid, if_pc, if_inst, if_adel
    );

    modport slave (
        output redirect_valid, redirect_pc, imem_gnt, imem_rvalid, imem_rdata, id_ready,
        input  imem_req, imem_addr, if_valid, if_pc, if_inst, if_adel
    );
endinterface

// File: rtl/inst_fetch_pf.sv
// rtl/inst_fetch_pf.sv - IF stage: PC generator, request tag queue and prefetch queue; IF_ADEL_EN adds address-error entries
module inst_fetch_pf #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst,
    inst_fetch_pf_if.master bus
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {S_BOOT, S_FETCH, S_DRAIN} state_t;
    state_t state, state_nxt;

    logic [31:0]   pc;
    logic [CW-1:0] inflight, discard, count, outstanding;
    logic [CW:0]   occ;
    logic [AW-1:0] q_rd, q_wr, t_rd, t_wr;
    logic [31:0]   q_pc   [FIFO_DEPTH];
    logic [31:0]   q_inst [FIFO_DEPTH];
    logic [31:0]   t_pc   [FIFO_DEPTH];

    logic          redir, resp, grant, pop, push, resp_push, valid, fetch_stop;
    logic [31:0]   push_pc, push_inst;

    assign redir       = bus.redirect_valid && (state != S_BOOT);
    assign resp        = bus.imem_rvalid && (inflight != '0);
    assign grant       = bus.imem_req && bus.imem_gnt;
    assign valid       = (count != '0);
    assign pop         = valid && bus.id_ready;
    assign occ         = {1'b0, count} + {1'b0, inflight};
    // Requests still owed a response after this cycle; becomes the drain count on redirect.
    assign outstanding = inflight + CW'(grant) - CW'(resp);
    assign resp_push   = resp && (state == S_FETCH) && !redir;

    assign bus.imem_req  = (state == S_FETCH) && (occ < (CW+1)'(FIFO_DEPTH)) && !fetch_stop;
    assign bus.imem_addr = pc;
    assign bus.if_valid  = valid;
    assign bus.if_pc     = valid ? q_pc[q_rd]   : 32'd0;
    assign bus.if_inst   = valid ? q_inst[q_rd] : 32'd0;

`ifdef IF_ADEL_EN
    logic        err, err_pending, err_push;
    logic [31:0] err_pc;
    logic        q_adel [FIFO_DEPTH];

    // The error entry waits until every stale response has been drained.
    assign err_push   = (state == S_FETCH) && err_pending && (inflight == '0) && !redir;
    assign push       = resp_push || err_push;
    assign push_pc    = err_push ? err_pc : t_pc[t_rd];
    assign push_inst  = err_push ? 32'd0  : bus.imem_rdata;
    assign fetch_stop = err;
    assign bus.if_adel = valid && q_adel[q_rd];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err         <= 1'b0;
            err_pending <= 1'b0;
            err_pc      <= 32'd0;
        end else if (redir) begin
            err         <= |bus.redirect_pc[1:0];
            err_pending <= |bus.redirect_pc[1:0];
            err_pc      <= bus.redirect_pc;
        end else if (err_push) begin
            err_pending <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (push) q_adel[q_wr] <= err_push;
    end
`else
    assign push        = resp_push;
    assign push_pc     = t_pc[t_rd];
    assign push_inst   = bus.imem_rdata;
    assign fetch_stop  = 1'b0;
    assign bus.if_adel = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_BOOT:  state_nxt = S_FETCH;
            S_FETCH: if (redir && (outstanding != '0)) state_nxt = S_DRAIN;
            S_DRAIN: if (resp && (discard == CW'(1))) state_nxt = S_FETCH;
            default: state_nxt = S_BOOT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_BOOT;
            pc       <= RESET_PC;
            inflight <= '0;
            discard  <= '0;
            count    <= '0;
            q_rd     <= '0;
            q_wr     <= '0;
            t_rd     <= '0;
            t_wr     <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= outstanding;
            if (redir)      pc <= bus.redirect_pc & 32'hFFFF_FFFC;
            else if (grant) pc <= pc + 32'd4;

            if ((state == S_FETCH) && redir && (outstanding != '0)) discard <= outstanding;
            else if ((state == S_DRAIN) && resp)                    discard <= discard - CW'(1);

            // Tags track every outstanding request, including ones that will be discarded.
            if (grant) t_wr <= t_wr + AW'(1);
            if (resp)  t_rd <= t_rd + AW'(1);

            if (redir) begin
                q_rd  <= '0;
                q_wr  <= '0;
                count <= '0;
            end else begin
                if (push) q_wr <= q_wr + AW'(1);
                if (pop)  q_rd <= q_rd + AW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (grant) t_pc[t_wr] <= pc;
        if (push) begin
            q_pc[q_wr]   <= push_pc;
            q_inst[q_wr] <= push_inst;
        end
    end
endmodule
